// File: rtl/dtw_pkg.sv
// rtl/dtw_pkg.sv - shared types and defaults for the DTW template classifier
package dtw_pkg;

    // Sequencer states; one template per LAUNCH..NEXT loop
    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_ARM,
        S_WAIT,
        S_EVAL,
        S_NEXT,
        S_DECIDE
    } dtw_state_e;

    localparam int                      DEF_DIST_W         = 12;
    localparam logic [DEF_DIST_W-1:0]   DIST_MAX           = '1;
    localparam logic [DEF_DIST_W-1:0]   DEF_REJECT_THR     = 12'd1500;
    localparam logic [DEF_DIST_W-1:0]   DEF_MARGIN         = 12'd40;
    localparam logic [23:0]             DEF_TIMEOUT_CYCLES = 24'd4000000;

endpackage

// File: rtl/dtw_template_classifier_if.sv
// rtl/dtw_template_classifier_if.sv - classifier-to-DTW-engine handshake bundle
interface dtw_template_classifier_if #(
    parameter int IDX_W  = 4,
    parameter int DIST_W = 12
);
    logic              dtw_start;
    logic [IDX_W-1:0]  tmpl_idx;
    logic              dist_valid;
    logic [DIST_W-1:0] dist_in;

    modport master (
        output dtw_start,
        output tmpl_idx,
        input  dist_valid,
        input  dist_in
    );

    modport slave (
        input  dtw_start,
        input  tmpl_idx,
        output dist_valid,
        output dist_in
    );
endinterface

// File: rtl/dtw_min2_tracker.sv
// rtl/dtw_min2_tracker.sv - running best and second-best distance tracker
module dtw_min2_tracker #(
    parameter int IDX_W  = 4,
    parameter int DIST_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              update,
    input  logic [DIST_W-1:0] d,
    input  logic [IDX_W-1:0]  idx,
    output logic [DIST_W-1:0] best_dist,
    output logic [DIST_W-1:0] second_dist,
    output logic [IDX_W-1:0]  best_idx
);

    // Strict compares so an equal later distance never displaces the lower index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_dist   <= '1;
            second_dist <= '1;
            best_idx    <= '0;
        end else if (clear) begin
            best_dist   <= '1;
            second_dist <= '1;
            best_idx    <= '0;
        end else if (update) begin
            if (d < best_dist) begin
                second_dist <= best_dist;
                best_dist   <= d;
                best_idx    <= idx;
            end else if (d < second_dist) begin
                second_dist <= d;
            end
        end
    end

endmodule

// File: rtl/dtw_template_classifier.sv
// rtl/dtw_template_classifier.sv - sequences templates through the DTW engine and decides a word
module dtw_template_classifier
    import dtw_pkg::*;
#(
    parameter int                NUM_TEMPLATES  = 8,
    parameter int                IDX_W          = 4,
    parameter int                DIST_W         = DEF_DIST_W,
    parameter logic [DIST_W-1:0] REJECT_THR     = DIST_W'(DEF_REJECT_THR),
    parameter logic [DIST_W-1:0] MARGIN         = DIST_W'(DEF_MARGIN),
    parameter logic [23:0]       TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    dtw_template_classifier_if.master   eng,
    output logic                        busy,
    output logic                        done,
    output logic [IDX_W-1:0]            best_idx,
    output logic [DIST_W-1:0]           best_dist,
    output logic                        reject,
    output logic                        timeout_err
);

    localparam logic [DIST_W-1:0] D_MAX    = '1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_TEMPLATES - 1);
    localparam logic [23:0]       TMO_LAST = TIMEOUT_CYCLES - 24'd1;

    dtw_state_e        state;
    dtw_state_e        state_nxt;
    logic [IDX_W-1:0]  tmpl_idx_q;
    logic              valid_q;
    logic [23:0]       tmo_cnt;
    logic              forced_q;
    logic              reject_q;
    logic              timeout_q;
    logic [DIST_W-1:0] second_dist;
    logic [DIST_W-1:0] eval_d;
    logic              valid_rise;
    logic              tmo_hit;
    logic              last_tmpl;
    logic              reject_now;
    logic              trk_clear;
    logic              trk_update;

    assign valid_rise = !valid_q && eng.dist_valid;
    assign tmo_hit    = (tmo_cnt == TMO_LAST);
    assign last_tmpl  = (tmpl_idx_q == LAST_IDX);
    assign eval_d     = forced_q ? D_MAX : eng.dist_in;
    assign trk_clear  = (state == S_IDLE) && start;
    assign trk_update = (state == S_EVAL);

    // second_dist >= best_dist always holds, so the difference cannot wrap
    assign reject_now = (best_dist > REJECT_THR)
                      | ((second_dist - best_dist) < MARGIN)
                      | (best_dist == D_MAX);

    assign eng.dtw_start = (state == S_LAUNCH);
    assign eng.tmpl_idx  = tmpl_idx_q;
    assign busy          = (state != S_IDLE);
    assign done          = (state == S_DECIDE);
    assign reject        = done ? reject_now : reject_q;
    assign timeout_err   = timeout_q;

    dtw_min2_tracker #(
        .IDX_W  (IDX_W),
        .DIST_W (DIST_W)
    ) u_tracker (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (trk_clear),
        .update      (trk_update),
        .d           (eval_d),
        .idx         (tmpl_idx_q),
        .best_dist   (best_dist),
        .second_dist (second_dist),
        .best_idx    (best_idx)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: one template per LAUNCH..NEXT pass, then a single DECIDE
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_LAUNCH;
            S_LAUNCH: state_nxt = S_ARM;
            S_ARM: begin
                if (tmo_hit)                state_nxt = S_EVAL;
                else if (!eng.dist_valid)   state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (valid_rise || tmo_hit)  state_nxt = S_EVAL;
            end
            S_EVAL:   state_nxt = S_NEXT;
            S_NEXT:   state_nxt = last_tmpl ? S_DECIDE : S_LAUNCH;
            S_DECIDE: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Previous dist_valid for rising-edge detection in WAIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= eng.dist_valid;
        end
    end

    // Template index, per-template timeout and held decision flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmpl_idx_q <= '0;
            tmo_cnt    <= '0;
            forced_q   <= 1'b0;
            reject_q   <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        tmpl_idx_q <= '0;
                        reject_q   <= 1'b0;
                        timeout_q  <= 1'b0;
                    end
                end
                S_LAUNCH: begin
                    tmo_cnt  <= '0;
                    forced_q <= 1'b0;
                end
                S_ARM: begin
                    tmo_cnt <= tmo_cnt + 24'd1;
                    if (tmo_hit) begin
                        forced_q  <= 1'b1;
                        timeout_q <= 1'b1;
                    end
                end
                S_WAIT: begin
                    tmo_cnt <= tmo_cnt + 24'd1;
                    if (!valid_rise && tmo_hit) begin
                        forced_q  <= 1'b1;
                        timeout_q <= 1'b1;
                    end
                end
                S_NEXT: begin
                    if (!last_tmpl) tmpl_idx_q <= tmpl_idx_q + IDX_W'(1);
                end
                S_DECIDE: begin
                    reject_q <= reject_now;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dtw_template_classifier.sv
// tb/tb_dtw_template_classifier.sv - randomized self-checking bench for dtw_template_classifier
module tb_dtw_template_classifier;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        busy;
    logic        done;
    logic [3:0]  best_idx;
    logic [11:0] best_dist;
    logic        reject;
    logic        timeout_err;

    int tests_run;
    int tests_failed;

    int eng_dist [4];
    int mute_idx;
    int hold_min;
    int starts_seen;
    int e_idx, e_hold, e_lat;
    bit e_active;

    int m_idx, m_dist, m_rej, m_tmo;

    dtw_template_classifier_if #(.IDX_W(4), .DIST_W(12)) eng ();

    dtw_template_classifier #(
        .NUM_TEMPLATES  (4),
        .IDX_W          (4),
        .DIST_W         (12),
        .REJECT_THR     (12'd1500),
        .MARGIN         (12'd40),
        .TIMEOUT_CYCLES (24'd50)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .eng         (eng),
        .busy        (busy),
        .done        (done),
        .best_idx    (best_idx),
        .best_dist   (best_dist),
        .reject      (reject),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural DTW engine: stale valid held a few cycles after start,
    // valid rises with garbage data, true distance settles one cycle later.
    initial begin
        eng.dist_valid = 1'b0;
        eng.dist_in    = '0;
        e_active       = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                eng.dist_valid = 1'b0;
                e_active       = 1'b0;
            end else if (eng.dtw_start) begin
                starts_seen++;
                e_idx    = int'(eng.tmpl_idx);
                e_hold   = hold_min + int'($urandom_range(0, 2));
                e_lat    = int'($urandom_range(2, 12));
                e_active = 1'b1;
                if (e_hold == 0) eng.dist_valid = 1'b0;
            end else if (e_active) begin
                if (e_hold > 0) begin
                    e_hold--;
                    if (e_hold == 0) eng.dist_valid = 1'b0;
                end else if (e_lat > 0) begin
                    e_lat--;
                    if (e_lat == 0 && e_idx != mute_idx) begin
                        eng.dist_valid = 1'b1;
                        eng.dist_in    = 12'($urandom);
                    end
                end else begin
                    if (e_idx != mute_idx) eng.dist_in = 12'(eng_dist[e_idx]);
                    e_active = 1'b0;
                end
            end
        end
    end

    // Reference decision from the distance list as a whole
    task automatic ref_model();
        int eff [4];
        int sec;
        for (int i = 0; i < 4; i++) eff[i] = (i == mute_idx) ? 4095 : eng_dist[i];
        m_idx = 0;
        for (int i = 1; i < 4; i++) if (eff[i] < eff[m_idx]) m_idx = i;
        m_dist = eff[m_idx];
        sec = 4095;
        for (int j = 0; j < 4; j++) if (j != m_idx && eff[j] < sec) sec = eff[j];
        m_rej = (m_dist > 1500 || (sec - m_dist) < 40 || m_dist == 4095) ? 1 : 0;
        m_tmo = (mute_idx >= 0) ? 1 : 0;
    endtask

    // Pulse start and wait (bounded) for done; leaves the bench at the done negedge
    task automatic do_run(input bit extra_start, output bit got_done);
        starts_seen = 0;
        got_done    = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (done) begin
                got_done = 1'b1;
                break;
            end
            start = (extra_start && cyc == 10) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic set_dists(input int a, input int b, input int c, input int d);
        eng_dist[0] = a; eng_dist[1] = b; eng_dist[2] = c; eng_dist[3] = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++; if (busy !== 1'b0)        begin tests_failed++; $display("FAIL reset_busy got %0b want 0", busy); end
        tests_run++; if (done !== 1'b0)        begin tests_failed++; $display("FAIL reset_done got %0b want 0", done); end
        tests_run++; if (eng.dtw_start !== 1'b0) begin tests_failed++; $display("FAIL reset_dtw_start got %0b want 0", eng.dtw_start); end
        tests_run++; if (eng.tmpl_idx !== 4'd0) begin tests_failed++; $display("FAIL reset_tmpl_idx got %0d want 0", eng.tmpl_idx); end
        tests_run++; if (best_idx !== 4'd0)    begin tests_failed++; $display("FAIL reset_best_idx got %0d want 0", best_idx); end
        tests_run++; if (best_dist !== 12'hFFF) begin tests_failed++; $display("FAIL reset_best_dist got %0d want 4095", best_dist); end
        tests_run++; if (reject !== 1'b0)      begin tests_failed++; $display("FAIL reset_reject got %0b want 0", reject); end
        tests_run++; if (timeout_err !== 1'b0) begin tests_failed++; $display("FAIL reset_timeout got %0b want 0", timeout_err); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_directed(input string name, input int a, input int b, input int c,
                                 input int d, input int mute, input int exp_idx,
                                 input int exp_dist, input int exp_rej, input int exp_tmo);
        bit ok;
        set_dists(a, b, c, d);
        mute_idx = mute;
        do_run(1'b0, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL %s_done got none want pulse", name); end
        tests_run++; if (starts_seen != 4) begin tests_failed++; $display("FAIL %s_starts got %0d want 4", name, starts_seen); end
        tests_run++; if (best_idx !== 4'(exp_idx)) begin tests_failed++; $display("FAIL %s_best_idx got %0d want %0d", name, best_idx, exp_idx); end
        tests_run++; if (best_dist !== 12'(exp_dist)) begin tests_failed++; $display("FAIL %s_best_dist got %0d want %0d", name, best_dist, exp_dist); end
        tests_run++; if (reject !== 1'(exp_rej)) begin tests_failed++; $display("FAIL %s_reject got %0b want %0d", name, reject, exp_rej); end
        tests_run++; if (timeout_err !== 1'(exp_tmo)) begin tests_failed++; $display("FAIL %s_timeout got %0b want %0d", name, timeout_err, exp_tmo); end
        @(negedge clk);
        tests_run++; if (done !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL %s_after got done=%0b busy=%0b want 0 0", name, done, busy); end
        tests_run++; if (reject !== 1'(exp_rej)) begin tests_failed++; $display("FAIL %s_reject_held got %0b want %0d", name, reject, exp_rej); end
        mute_idx = -1;
    endtask

    task automatic test_reset_midrun();
        bit ok;
        set_dists(700, 650, 900, 800);
        mute_idx = -1;
        starts_seen = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ok = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (eng.tmpl_idx == 4'd1 && busy) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL midrun_reach got none want tmpl_idx 1"); end
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests_run++; if (busy !== 1'b0 || done !== 1'b0 || eng.dtw_start !== 1'b0)
            begin tests_failed++; $display("FAIL midrun_ctrl got busy=%0b done=%0b start=%0b want 0", busy, done, eng.dtw_start); end
        tests_run++; if (eng.tmpl_idx !== 4'd0 || best_idx !== 4'd0 || best_dist !== 12'hFFF)
            begin tests_failed++; $display("FAIL midrun_data got idx=%0d best=%0d dist=%0d want 0 0 4095", eng.tmpl_idx, best_idx, best_dist); end
        tests_run++; if (reject !== 1'b0 || timeout_err !== 1'b0)
            begin tests_failed++; $display("FAIL midrun_flags got rej=%0b tmo=%0b want 0 0", reject, timeout_err); end
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        // Fresh run with a start pulsed while busy, which must be ignored
        set_dists(int'($urandom_range(0, 2200)), int'($urandom_range(0, 2200)),
                  int'($urandom_range(0, 2200)), int'($urandom_range(0, 2200)));
        ref_model();
        do_run(1'b1, ok);
        tests_run++; if (!ok) begin tests_failed++; $display("FAIL rerun_done got none want pulse"); end
        tests_run++; if (best_idx !== 4'(m_idx) || best_dist !== 12'(m_dist) || reject !== 1'(m_rej))
            begin tests_failed++; $display("FAIL rerun_result got %0d/%0d/%0b want %0d/%0d/%0d", best_idx, best_dist, reject, m_idx, m_dist, m_rej); end
        repeat (20) @(negedge clk);
        tests_run++; if (starts_seen != 4 || busy !== 1'b0)
            begin tests_failed++; $display("FAIL busy_start_ignored got starts=%0d busy=%0b want 4 0", starts_seen, busy); end
    endtask

    task automatic test_random();
        bit ok;
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < 4; i++) eng_dist[i] = int'($urandom_range(0, 2200));
            if ($urandom_range(0, 2) == 0) eng_dist[3] = eng_dist[1] + int'($urandom_range(0, 60));
            mute_idx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
            ref_model();
            do_run(1'b0, ok);
            tests_run++;
            if (!ok || starts_seen != 4 || best_idx !== 4'(m_idx) || best_dist !== 12'(m_dist)
                || reject !== 1'(m_rej) || timeout_err !== 1'(m_tmo)) begin
                tests_failed++;
                $display("FAIL random_%0d got done=%0b starts=%0d idx=%0d dist=%0d rej=%0b tmo=%0b want 1 4 %0d %0d %0d %0d",
                         r, ok, starts_seen, best_idx, best_dist, reject, timeout_err, m_idx, m_dist, m_rej, m_tmo);
            end
            @(negedge clk);
        end
        mute_idx = -1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        start        = 1'b0;
        mute_idx     = -1;
        hold_min     = 0;
        starts_seen  = 0;
        for (int i = 0; i < 4; i++) eng_dist[i] = 0;

        test_reset();
        test_directed("basic",     300,  120,  500,  200, -1, 1,  120, 0, 0);
        test_directed("margin",    300,  120,  130,  400, -1, 1,  120, 1, 0);
        test_directed("threshold", 2000, 1800, 1900, 1700, -1, 3, 1700, 1, 0);
        hold_min = 2;
        test_directed("tie",       150,  150,  400,  400, -1, 0,  150, 1, 0);
        hold_min = 0;
        test_directed("timeout",   300,  120,  500,  200,  2, 1,  120, 0, 1);
        test_reset_midrun();
        test_random();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
